// File: rtl/prog_mem.sv
// prog_mem: multi-slot writable program store for the washing register machine.
// Holds NUM_SLOTS programs of SLOT_SIZE words each. After reset (or a reload
// pulse) it clears every word to halt (0), then loads the standard wash program
// into slot 0, then enters RUN where fetches and writes are serviced.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   reload            pulse in RUN: re-run initialisation
//   ready             high in RUN
//   rd_en/slot_sel/pc fetch request; instr/instr_valid returned one cycle later
//   wr_valid/wr_ready handshaked write of wr_data to (wr_slot, wr_addr)
//   err               one-cycle pulse after an out-of-range fetch and/or write
module prog_mem #(
  parameter int INSTR_WIDTH = 32,
  parameter int ADDR_WIDTH  = 8,
  parameter int SLOT_SIZE   = 64,
  parameter int NUM_SLOTS   = 4,
  parameter int SLOT_BITS   = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   reload,
  output logic                   ready,
  input  logic                   rd_en,
  input  logic [SLOT_BITS-1:0]   slot_sel,
  input  logic [ADDR_WIDTH-1:0]  pc,
  output logic [INSTR_WIDTH-1:0] instr,
  output logic                   instr_valid,
  input  logic                   wr_valid,
  output logic                   wr_ready,
  input  logic [SLOT_BITS-1:0]   wr_slot,
  input  logic [ADDR_WIDTH-1:0]  wr_addr,
  input  logic [INSTR_WIDTH-1:0] wr_data,
  output logic                   err
);

  localparam int TOTAL = NUM_SLOTS * SLOT_SIZE;
  localparam int IDX_W = $clog2(TOTAL);
  localparam int CNT_W = $clog2(TOTAL + 1);

  localparam logic [1:0] S_INIT_CLEAR = 2'd0;
  localparam logic [1:0] S_INIT_LOAD  = 2'd1;
  localparam logic [1:0] S_RUN        = 2'd2;

  localparam logic [CNT_W-1:0]      CNT_CLR_LAST  = CNT_W'(TOTAL - 1);
  localparam logic [CNT_W-1:0]      CNT_LOAD_LAST = CNT_W'(9);
  localparam logic [ADDR_WIDTH:0]   ADDR_LIM      = (ADDR_WIDTH + 1)'(SLOT_SIZE);
  localparam logic [SLOT_BITS:0]    SLOT_LIM      = (SLOT_BITS + 1)'(NUM_SLOTS);

  logic [1:0]             r_state;
  logic [CNT_W-1:0]       r_cnt;
  logic [INSTR_WIDTH-1:0] r_instr;
  logic                   r_valid;
  logic                   r_err;
  logic [INSTR_WIDTH-1:0] r_mem [TOTAL];

  logic                   w_rd_ok;
  logic                   w_wr_ok;
  logic [IDX_W-1:0]       w_rd_idx;
  logic [IDX_W-1:0]       w_wr_idx;
  logic                   w_mem_we;
  logic [IDX_W-1:0]       w_mem_idx;
  logic [INSTR_WIDTH-1:0] w_mem_wdata;

  // Standard wash program, word i lands at slot 0 address i+2.
  // Encoding {arg[15:0], reg[7:0], opcode[7:0]}, reg always 0.
  function automatic logic [INSTR_WIDTH-1:0] std_word(input logic [3:0] i);
    logic [15:0] arg;
    logic [7:0]  op;
    arg = '0;
    op  = '0;
    case (i)
      4'd0: begin arg = 16'd100; op = 8'h02; end
      4'd1: begin arg = 16'd50;  op = 8'h01; end
      4'd2: begin arg = 16'd5;   op = 8'h11; end
      4'd3: begin arg = 16'd20;  op = 8'h04; end
      4'd4: begin arg = 16'd10;  op = 8'h01; end
      4'd5: begin arg = 16'd20;  op = 8'h05; end
      4'd6: begin arg = 16'd10;  op = 8'h01; end
      4'd7: begin arg = 16'd0;   op = 8'h12; end
      4'd8: begin arg = 16'd5;   op = 8'h22; end
      4'd9: begin arg = 16'd100; op = 8'h03; end
      default: begin arg = '0; op = '0; end
    endcase
    return INSTR_WIDTH'({arg, 8'h00, op});
  endfunction

  assign w_rd_ok  = ({1'b0, pc} < ADDR_LIM) && ({1'b0, slot_sel} < SLOT_LIM);
  assign w_wr_ok  = ({1'b0, wr_addr} < ADDR_LIM) && ({1'b0, wr_slot} < SLOT_LIM);
  assign w_rd_idx = IDX_W'(slot_sel) * IDX_W'(SLOT_SIZE) + IDX_W'(pc);
  assign w_wr_idx = IDX_W'(wr_slot) * IDX_W'(SLOT_SIZE) + IDX_W'(wr_addr);

  // Single memory write port shared by clearing, program load and run-time writes.
  always_comb begin
    w_mem_we    = 1'b0;
    w_mem_idx   = '0;
    w_mem_wdata = '0;
    case (r_state)
      S_INIT_CLEAR: begin
        w_mem_we  = 1'b1;
        w_mem_idx = IDX_W'(r_cnt);
      end
      S_INIT_LOAD: begin
        w_mem_we    = 1'b1;
        w_mem_idx   = IDX_W'(r_cnt) + IDX_W'(2);
        w_mem_wdata = std_word(r_cnt[3:0]);
      end
      S_RUN: begin
        w_mem_we    = wr_valid && w_wr_ok;
        w_mem_idx   = w_wr_idx;
        w_mem_wdata = wr_data;
      end
      default: begin
        w_mem_we = 1'b0;
      end
    endcase
  end

  // Contents are not reset; initialisation rewrites every word.
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[w_mem_idx] <= w_mem_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_INIT_CLEAR;
      r_cnt   <= '0;
      r_instr <= '0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      case (r_state)
        S_INIT_CLEAR: begin
          if (r_cnt == CNT_CLR_LAST) begin
            r_state <= S_INIT_LOAD;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_INIT_LOAD: begin
          if (r_cnt == CNT_LOAD_LAST) begin
            r_state <= S_RUN;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_RUN: begin
          // Read uses pre-edge memory contents, so a same-word write is read-first.
          if (rd_en) begin
            r_valid <= 1'b1;
            r_instr <= w_rd_ok ? r_mem[w_rd_idx] : '0;
          end
          r_err <= (rd_en && !w_rd_ok) || (wr_valid && !w_wr_ok);
          if (reload) begin
            r_state <= S_INIT_CLEAR;
            r_cnt   <= '0;
          end
        end
        default: begin
          r_state <= S_INIT_CLEAR;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign ready       = (r_state == S_RUN);
  assign wr_ready    = (r_state == S_RUN);
  assign instr       = r_instr;
  assign instr_valid = r_valid;
  assign err         = r_err;

endmodule

// File: tb/tb_prog_mem.sv
module tb_prog_mem;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        reload = 1'b0;
  logic        rd_en = 1'b0;
  logic [1:0]  slot_sel = '0;
  logic [7:0]  pc = '0;
  logic        wr_valid = 1'b0;
  logic [1:0]  wr_slot = '0;
  logic [7:0]  wr_addr = '0;
  logic [31:0] wr_data = '0;

  logic        ready, wr_ready, instr_valid, err;
  logic [31:0] instr;
  logic        ready3, wr_ready3, instr_valid3, err3;
  logic [31:0] instr3;

  always #5 clk = ~clk;

  prog_mem #(
    .INSTR_WIDTH(32), .ADDR_WIDTH(8), .SLOT_SIZE(64), .NUM_SLOTS(4), .SLOT_BITS(2)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .reload(reload), .ready(ready),
    .rd_en(rd_en), .slot_sel(slot_sel), .pc(pc), .instr(instr), .instr_valid(instr_valid),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_slot(wr_slot), .wr_addr(wr_addr),
    .wr_data(wr_data), .err(err)
  );

  // Three-slot variant: slot index 3 is out of range here.
  prog_mem #(
    .INSTR_WIDTH(32), .ADDR_WIDTH(8), .SLOT_SIZE(64), .NUM_SLOTS(3), .SLOT_BITS(2)
  ) u_dut3 (
    .clk(clk), .rst_n(rst_n), .reload(reload), .ready(ready3),
    .rd_en(rd_en), .slot_sel(slot_sel), .pc(pc), .instr(instr3), .instr_valid(instr_valid3),
    .wr_valid(wr_valid), .wr_ready(wr_ready3), .wr_slot(wr_slot), .wr_addr(wr_addr),
    .wr_data(wr_data), .err(err3)
  );

  typedef struct {
    logic        v;
    logic [31:0] d;
    logic        e;
  } exp_t;

  exp_t        q[$];
  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] model [4][64];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (instr_valid || err) begin
      n_checks++;
      if (q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_output: instr_valid=%0b instr=0x%08h err=%0b with nothing expected",
                 instr_valid, instr, err);
      end else begin
        e = q.pop_front();
        if ((instr_valid !== e.v) || (e.v && (instr !== e.d)) || (err !== e.e)) begin
          n_fail++;
          $display("FAIL fetch_response: got valid=%0b instr=0x%08h err=%0b expected valid=%0b instr=0x%08h err=%0b",
                   instr_valid, instr, err, e.v, e.d, e.e);
        end
      end
    end
  end

  task automatic model_init();
    for (int s = 0; s < 4; s++)
      for (int p = 0; p < 64; p++)
        model[s][p] = '0;
    model[0][2]  = 32'h00640002;
    model[0][3]  = 32'h00320001;
    model[0][4]  = 32'h00050011;
    model[0][5]  = 32'h00140004;
    model[0][6]  = 32'h000A0001;
    model[0][7]  = 32'h00140005;
    model[0][8]  = 32'h000A0001;
    model[0][9]  = 32'h00000012;
    model[0][10] = 32'h00050022;
    model[0][11] = 32'h00640003;
  endtask

  // One cycle of stimulus, applied just after a falling edge.
  task automatic cyc(input logic rd, input logic [1:0] s, input logic [7:0] p,
                     input logic [31:0] ed, input logic ee,
                     input logic wv, input logic [1:0] ws, input logic [7:0] wa,
                     input logic [31:0] wd, input logic rl);
    exp_t e;
    rd_en = rd; slot_sel = s; pc = p;
    wr_valid = wv; wr_slot = ws; wr_addr = wa; wr_data = wd;
    reload = rl;
    if (rd) begin
      e.v = 1'b1; e.d = ed; e.e = ee; q.push_back(e);
    end else if (ee) begin
      e.v = 1'b0; e.d = '0; e.e = 1'b1; q.push_back(e);
    end
    if (wv) begin
      chk("wr_ready_on_write", {31'b0, wr_ready}, 32'd1);
      if (wa < 8'd64) model[ws][wa] = wd;
    end
    @(negedge clk);
    rd_en = 1'b0; wr_valid = 1'b0; reload = 1'b0;
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic scan();
    for (int s = 0; s < 4; s++)
      for (int p = 0; p < 64; p++)
        cyc(1, 2'(s), 8'(p), model[s][p], 0, 0, 0, 0, 0, 0);
    idle();
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!ready && n < 2000) begin
      @(posedge clk);
      n++;
      #1;
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready"}, {31'b0, ready}, 32'd0);
    chk({tag, "_wr_ready"}, {31'b0, wr_ready}, 32'd0);
    chk({tag, "_instr"}, instr, 32'd0);
    chk({tag, "_instr_valid"}, {31'b0, instr_valid}, 32'd0);
    chk({tag, "_err"}, {31'b0, err}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int   n;
    int   wr_bad;
    exp_t e;

    model_init();
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");

    rst_n = 1'b1;
    wait_ready(n);
    chk("init_cycles", n, 266);
    @(negedge clk);

    cyc(1, 0, 8'd2,  32'h00640002, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 8'd10, 32'h00050022, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 8'd11, 32'h00640003, 0, 0, 0, 0, 0, 0);
    scan();

    cyc(0, 0, 0, 0, 0, 1, 2'd2, 8'd7, 32'hDEADBEEF, 0);
    cyc(1, 2'd2, 8'd7, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0);
    cyc(1, 2'd1, 8'd7, 32'h00000000, 0, 0, 0, 0, 0, 0);

    cyc(1, 2'd1, 8'd3, 32'h00000000, 0, 1, 2'd1, 8'd3, 32'h12345678, 0);
    cyc(1, 2'd1, 8'd3, 32'h12345678, 0, 0, 0, 0, 0, 0);

    cyc(1, 0, 8'd64,  32'h0, 1, 0, 0, 0, 0, 0);
    cyc(1, 0, 8'd255, 32'h0, 1, 0, 0, 0, 0, 0);
    idle();
    cyc(0, 0, 0, 0, 1, 1, 2'd0, 8'd70, 32'hFFFFFFFF, 0);
    idle();
    cyc(1, 0, 8'd100, 32'h0, 1, 1, 2'd1, 8'd200, 32'hAAAA5555, 0);
    idle();

    chk("dut3_ready", {31'b0, ready3}, 32'd1);
    chk("dut3_wr_ready", {31'b0, wr_ready3}, 32'd1);
    cyc(1, 0, 8'd2, 32'h00640002, 0, 0, 0, 0, 0, 0);
    cyc(1, 2'd3, 8'd5, model[3][5], 0, 0, 0, 0, 0, 0);
    chk("dut3_oor_slot_valid", {31'b0, instr_valid3}, 32'd1);
    chk("dut3_oor_slot_instr", instr3, 32'd0);
    chk("dut3_oor_slot_err", {31'b0, err3}, 32'd1);
    idle();
    chk("dut3_err_single_pulse", {31'b0, err3}, 32'd0);

    scan();

    cyc(1, 0, 8'd2, 32'h00640002, 0, 0, 0, 0, 0, 1);
    n = 0;
    wr_bad = 0;
    while (!ready && n < 2000) begin
      if (wr_ready) wr_bad++;
      n++;
      @(negedge clk);
    end
    chk("reload_ready_low_cycles", n, 266);
    chk("reload_wr_ready_low", wr_bad, 0);
    model_init();
    cyc(1, 2'd2, 8'd7, 32'h00000000, 0, 0, 0, 0, 0, 0);
    scan();

    cyc(1, 0, 8'd2, 32'h00640002, 0, 0, 0, 0, 0, 1);
    rd_en = 1'b1; slot_sel = 2'd0; pc = 8'd11;
    repeat (100) @(negedge clk);
    chk("instr_hold_during_init", instr, 32'h00640002);
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs("midinit_reset");
    @(negedge clk);
    rst_n = 1'b1;
    wait_ready(n);
    chk("reinit_cycles", n, 266);
    e.v = 1'b1; e.d = 32'h00640003; e.e = 1'b0;
    q.push_back(e);
    @(posedge clk);
    #1 rd_en = 1'b0;
    @(negedge clk);
    idle();
    idle();
    chk("scoreboard_drained", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
